// File: rtl/shift_align_stream_pkg.sv
// Shared types and width helpers for the shift-align stream block.
// The package name matches the one the rest of the parser code imports.
package parser_shift_pkg;

  localparam int TAG_LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_HOLD,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic                 first;
    logic                 last;
    logic [TAG_LEN_W-1:0] len;
  } tag_t;

  function automatic int len_w(input int data_w, input int unit_w);
    return $clog2(data_w / unit_w + 1);
  endfunction

  // One spare bit so an out-of-range shift can still be presented and flagged.
  function automatic int shift_w(input int candi_num);
    return $clog2(candi_num + 1);
  endfunction

endpackage

// File: rtl/shift_align_stream_if.sv
// Upstream/downstream beat bus of the shift-align stream block.
// The names follow the block's i_/o_ port list; master drives the i_ side.
interface shift_align_stream_if #(
  parameter int DATA_W    = 512,
  parameter int UNIT_W    = 8,
  parameter int CANDI_NUM = 64
) ();
  localparam int LEN_W   = parser_shift_pkg::len_w(DATA_W, UNIT_W);
  localparam int SHIFT_W = parser_shift_pkg::shift_w(CANDI_NUM);

  logic               i_data_valid;
  logic               o_data_ready;
  logic [DATA_W-1:0]  i_data;
  logic               i_first;
  logic               i_last;
  logic [LEN_W-1:0]   i_len;
  logic [SHIFT_W-1:0] i_shift;
  logic               o_data_valid;
  logic               i_data_ready;
  logic [DATA_W-1:0]  o_data;
  logic               o_first;
  logic               o_last;
  logic [LEN_W-1:0]   o_len;
  logic               o_shift_err;

  modport master (
    output i_data_valid, i_data, i_first, i_last, i_len, i_shift, i_data_ready,
    input  o_data_ready, o_data_valid, o_data, o_first, o_last, o_len, o_shift_err
  );

  modport slave (
    input  i_data_valid, i_data, i_first, i_last, i_len, i_shift, i_data_ready,
    output o_data_ready, o_data_valid, o_data, o_first, o_last, o_len, o_shift_err
  );

endinterface

// File: rtl/shift_align_stream_shift_mux.sv
// Unit-offset window selector: picks DATA_W bits of {hi, lo} starting
// sel units below the MSB, for sel in 0..CANDI_NUM-1.
module shift_mux #(
  parameter int DATA_W    = 512,
  parameter int UNIT_W    = 8,
  parameter int CANDI_NUM = 64,
  parameter int SHIFT_W   = parser_shift_pkg::shift_w(CANDI_NUM)
) (
  input  logic [DATA_W-1:0]  hi,
  input  logic [DATA_W-1:0]  lo,
  input  logic [SHIFT_W-1:0] sel,
  output logic [DATA_W-1:0]  dout
);
  localparam int TAIL_W = DATA_W - (CANDI_NUM - 1) * UNIT_W;

  logic [2*DATA_W-1:0] cat;
  logic [TAIL_W-1:0]   tail_unused;

  assign cat         = {hi, lo};
  // The lowest units of lo can never reach the window.
  assign tail_unused = cat[TAIL_W-1:0];

  always_comb begin
    dout = '0;
    for (int i = 0; i < CANDI_NUM; i++) begin
      if (sel == SHIFT_W'(i)) dout = cat[2*DATA_W-1-i*UNIT_W -: DATA_W];
    end
  end

endmodule

// File: rtl/shift_align_stream.sv
// Strips a per-packet head shift from a beat stream and re-packs the
// remaining units MSB-aligned into full output beats.
//
// state    | meaning
// ST_IDLE  | waiting for a packet's first beat
// ST_PASS  | shift 0, beats forwarded with one cycle latency
// ST_HOLD  | shift > 0, previous beat held in r_prev
// ST_FLUSH | one residual beat pending, upstream stalled
module shift_align_stream
  import parser_shift_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int UNIT_W    = 8,
  parameter int CANDI_NUM = 64
) (
  input logic                 i_clk,
  input logic                 i_rst,
  shift_align_stream_if.slave bus
);
  localparam int K       = DATA_W / UNIT_W;
  localparam int LEN_W   = len_w(DATA_W, UNIT_W);
  localparam int SHIFT_W = shift_w(CANDI_NUM);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(K);

  state_t             r_state, n_state, r_fnext, n_fnext;
  logic [DATA_W-1:0]  r_prev, n_prev, r_odata, n_odata;
  logic [DATA_W-1:0]  dm, mux_lo, mux_out;
  logic [SHIFT_W-1:0] r_shift, n_shift, new_s;
  logic               r_first_pend, n_first_pend;
  logic               r_ovalid, n_ovalid, r_err, n_err;
  tag_t               r_otag, n_otag, r_ftag, n_ftag;
  logic               out_free, acc, new_bad, do_close;
  logic [LEN_W-1:0]   s_len, new_s_len;
  logic [TAG_LEN_W-LEN_W-1:0] tag_len_unused;

  function automatic tag_t mk_tag(input logic f, input logic l, input logic [LEN_W-1:0] len);
    tag_t t;
    t.first = f;
    t.last  = l;
    t.len   = TAG_LEN_W'(len);
    return t;
  endfunction

  assign out_free         = ~r_ovalid | bus.i_data_ready;
  assign bus.o_data_ready = out_free & (r_state != ST_FLUSH);
  assign acc              = bus.i_data_valid & bus.o_data_ready;
  assign new_bad          = bus.i_shift >= SHIFT_W'(CANDI_NUM);
  assign new_s            = new_bad ? '0 : bus.i_shift;
  assign new_s_len        = LEN_W'(new_s);
  assign s_len            = LEN_W'(r_shift);
  // A first beat while a packet is open closes that packet this cycle.
  assign do_close         = acc & bus.i_first & (r_state != ST_IDLE);
  assign mux_lo           = (r_state == ST_FLUSH || do_close) ? '0 : dm;

  // Units past i_len on a last beat are forced to zero.
  always_comb begin
    dm = bus.i_data;
    if (bus.i_last) begin
      for (int u = 0; u < K; u++) begin
        if (LEN_W'(u) >= bus.i_len) dm[DATA_W-1-u*UNIT_W -: UNIT_W] = '0;
      end
    end
  end

  shift_mux #(
    .DATA_W   (DATA_W),
    .UNIT_W   (UNIT_W),
    .CANDI_NUM(CANDI_NUM),
    .SHIFT_W  (SHIFT_W)
  ) u_shift_mux (
    .hi  (r_prev),
    .lo  (mux_lo),
    .sel (r_shift),
    .dout(mux_out)
  );

  always_comb begin
    n_state      = r_state;
    n_prev       = r_prev;
    n_shift      = r_shift;
    n_first_pend = r_first_pend;
    n_ftag       = r_ftag;
    n_fnext      = r_fnext;
    n_odata      = r_odata;
    n_otag       = r_otag;
    n_ovalid     = r_ovalid & ~bus.i_data_ready;
    n_err        = 1'b0;

    if (r_state == ST_FLUSH) begin
      if (out_free) begin
        n_ovalid = 1'b1;
        n_odata  = mux_out;
        n_otag   = r_ftag;
        n_state  = r_fnext;
      end
    end else if (acc && bus.i_first) begin
      n_err   = new_bad;
      n_shift = new_s;
      if (r_state == ST_HOLD) begin
        n_ovalid = 1'b1;
        n_odata  = mux_out;
        n_otag   = mk_tag(r_first_pend, 1'b1, LEN_FULL - s_len);
      end else if (r_state == ST_PASS) begin
        n_ovalid = 1'b1;
        n_odata  = '0;
        n_otag   = mk_tag(1'b0, 1'b1, '0);
      end

      if (new_s != '0) begin
        n_prev       = dm;
        n_first_pend = 1'b1;
        if (bus.i_last) begin
          n_state = ST_FLUSH;
          n_ftag  = mk_tag(1'b1, 1'b1, (bus.i_len > new_s_len) ? bus.i_len - new_s_len : '0);
          n_fnext = ST_IDLE;
        end else begin
          n_state = ST_HOLD;
        end
      end else if (r_state == ST_IDLE) begin
        n_ovalid = 1'b1;
        n_odata  = dm;
        n_otag   = mk_tag(1'b1, bus.i_last, bus.i_last ? bus.i_len : LEN_FULL);
        n_state  = bus.i_last ? ST_IDLE : ST_PASS;
      end else begin
        // Output slot already used by the close beat; park the new beat.
        n_prev  = dm;
        n_state = ST_FLUSH;
        n_ftag  = mk_tag(1'b1, bus.i_last, bus.i_last ? bus.i_len : LEN_FULL);
        n_fnext = bus.i_last ? ST_IDLE : ST_PASS;
      end
    end else if (acc) begin
      if (r_state == ST_PASS) begin
        n_ovalid = 1'b1;
        n_odata  = dm;
        n_otag   = mk_tag(1'b0, bus.i_last, bus.i_last ? bus.i_len : LEN_FULL);
        if (bus.i_last) n_state = ST_IDLE;
      end else if (r_state == ST_HOLD) begin
        n_ovalid     = 1'b1;
        n_odata      = mux_out;
        n_prev       = dm;
        n_first_pend = 1'b0;
        if (!bus.i_last) begin
          n_otag = mk_tag(r_first_pend, 1'b0, LEN_FULL);
        end else if (bus.i_len > s_len) begin
          n_otag  = mk_tag(r_first_pend, 1'b0, LEN_FULL);
          n_state = ST_FLUSH;
          n_ftag  = mk_tag(1'b0, 1'b1, bus.i_len - s_len);
          n_fnext = ST_IDLE;
        end else begin
          n_otag  = mk_tag(r_first_pend, 1'b1, LEN_FULL - s_len + bus.i_len);
          n_state = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_fnext      <= ST_IDLE;
      r_prev       <= '0;
      r_shift      <= '0;
      r_first_pend <= 1'b0;
      r_ftag       <= '0;
      r_odata      <= '0;
      r_otag       <= '0;
      r_ovalid     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= n_state;
      r_fnext      <= n_fnext;
      r_prev       <= n_prev;
      r_shift      <= n_shift;
      r_first_pend <= n_first_pend;
      r_ftag       <= n_ftag;
      r_odata      <= n_odata;
      r_otag       <= n_otag;
      r_ovalid     <= n_ovalid;
      r_err        <= n_err;
    end
  end

  assign bus.o_data_valid = r_ovalid;
  assign bus.o_data       = r_odata;
  assign bus.o_first      = r_otag.first;
  assign bus.o_last       = r_otag.last;
  assign bus.o_len        = r_otag.len[LEN_W-1:0];
  assign bus.o_shift_err  = r_err;
  assign tag_len_unused   = r_otag.len[TAG_LEN_W-1:LEN_W];

endmodule
